// File: rtl/chip8_pkg.sv
// chip8_pkg: shared CHIP-8 system constants and loader/receiver state encodings.
// Optional feature macro: UART_LOADER_CHECKSUM_EN adds the LS_CSUM loader state.
package chip8_pkg;

    localparam int unsigned MEM_ADDR_W  = 12;
    localparam int unsigned LEN_W       = 16;
    localparam logic [MEM_ADDR_W-1:0] ROM_BASE = 12'h200;
    localparam int unsigned ROM_MAX_LEN = 3584;

    typedef enum logic [2:0] {
        LS_LEN_HI,
        LS_LEN_LO,
        LS_DATA,
`ifdef UART_LOADER_CHECKSUM_EN
        LS_CSUM,
`endif
        LS_DONE,
        LS_ERR
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rom_loader_if.sv
// uart_rom_loader_if: memory write bus driven by the loader during program load.
//   mem_we    : one-cycle write strobe
//   mem_addr  : 12-bit write address
//   mem_wdata : 8-bit write data
interface uart_rom_loader_if;

    logic                               mem_we;
    logic [chip8_pkg::MEM_ADDR_W-1:0]   mem_addr;
    logic [7:0]                         mem_wdata;

    modport master (output mem_we, output mem_addr, output mem_wdata);
    modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);

endinterface

// File: rtl/uart_rom_loader_uart_rx.sv
// uart_rx: 8N1 UART receiver with 2-flop input synchronizer.
//   clk_in, rst_in (sync, active-low), rx_in (async serial line)
//   byte_valid : one-cycle pulse, byte_data holds the received byte
//   frame_err  : one-cycle pulse when the stop bit sampled low (byte dropped)
module uart_rx
    import chip8_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rx_in,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic            r_sync1, r_sync2, r_sync3;
    rx_state_t       r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic [2:0]      r_bit_idx, w_bit_n;
    logic [7:0]      r_shift, w_shift_n;
    logic            r_valid, w_valid_n;
    logic [7:0]      r_data, w_data_n;
    logic            r_ferr, w_ferr_n;

    // Next-state: start detection, mid-bit sampling, stop check
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt + CNT_W'(1);
        w_bit_n   = r_bit_idx;
        w_shift_n = r_shift;
        w_valid_n = 1'b0;
        w_data_n  = r_data;
        w_ferr_n  = 1'b0;
        unique case (r_state)
            RX_IDLE: begin
                w_cnt_n = '0;
                if (r_sync3 && !r_sync2) w_state_n = RX_START;
            end
            RX_START: begin
                if (r_cnt == HALF_M1) begin
                    // Line back high at mid-start means a glitch, not a frame
                    w_cnt_n   = '0;
                    w_bit_n   = '0;
                    w_state_n = r_sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_n   = '0;
                    w_shift_n = {r_sync2, r_shift[7:1]};
                    w_bit_n   = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) w_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_n   = '0;
                    w_state_n = RX_IDLE;
                    if (r_sync2) begin
                        w_valid_n = 1'b1;
                        w_data_n  = r_shift;
                    end else begin
                        w_ferr_n  = 1'b1;
                    end
                end
            end
            default: w_state_n = RX_IDLE;
        endcase
    end

    // State register and synchronizer
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_sync3   <= 1'b1;
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_ferr    <= 1'b0;
        end else begin
            r_sync1   <= rx_in;
            r_sync2   <= r_sync1;
            r_sync3   <= r_sync2;
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_bit_idx <= w_bit_n;
            r_shift   <= w_shift_n;
            r_valid   <= w_valid_n;
            r_data    <= w_data_n;
            r_ferr    <= w_ferr_n;
        end
    end

    assign byte_valid = r_valid;
    assign byte_data  = r_data;
    assign frame_err  = r_ferr;

endmodule

// File: rtl/uart_rom_loader.sv
// uart_rom_loader: receives a length-prefixed CHIP-8 program over UART and
// writes it to memory from LOAD_BASE, then raises rom_ready (sticky).
//   clk_in, rst_in (sync, active-low), rx_in (UART 8N1)
//   mem       : master side of the memory write bus (we/addr/wdata, registered)
//   rom_ready : program loaded; load_err : load aborted (both sticky)
// Optional feature macro: UART_LOADER_CHECKSUM_EN (trailing 8-bit sum byte).
module uart_rom_loader
    import chip8_pkg::*;
#(
    parameter int unsigned           CLKS_PER_BIT = 868,
    parameter logic [MEM_ADDR_W-1:0] LOAD_BASE    = ROM_BASE,
    parameter int unsigned           MAX_LEN      = ROM_MAX_LEN
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rx_in,
    uart_rom_loader_if.master      mem,
    output logic                   rom_ready,
    output logic                   load_err
);

    logic       w_byte_valid;
    logic [7:0] w_byte_data;
    logic       w_frame_err;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rx_in      (rx_in),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte_data),
        .frame_err  (w_frame_err)
    );

    loader_state_t          r_state, w_state_n;
    logic [LEN_W-1:0]       r_len, w_len_n;
    logic [MEM_ADDR_W-1:0]  r_count, w_count_n;
    logic                   r_mem_we, w_we_n;
    logic [MEM_ADDR_W-1:0]  r_mem_addr, w_addr_n;
    logic [7:0]             r_mem_wdata, w_wdata_n;
    logic                   r_rom_ready, r_load_err;
    logic [LEN_W-1:0]       w_len_full;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]             r_sum, w_sum_n;
`endif

    assign w_len_full = {r_len[15:8], w_byte_data};

    // Next-state: frame parsing and write generation
    always_comb begin
        w_state_n = r_state;
        w_len_n   = r_len;
        w_count_n = r_count;
        w_we_n    = 1'b0;
        w_addr_n  = r_mem_addr;
        w_wdata_n = r_mem_wdata;
`ifdef UART_LOADER_CHECKSUM_EN
        w_sum_n   = r_sum;
`endif
        if (w_frame_err && r_state != LS_DONE && r_state != LS_ERR) begin
            w_state_n = LS_ERR;
        end else if (w_byte_valid) begin
            unique case (r_state)
                LS_LEN_HI: begin
                    w_len_n[15:8] = w_byte_data;
                    w_state_n     = LS_LEN_LO;
                end
                LS_LEN_LO: begin
                    w_len_n = w_len_full;
                    if (w_len_full == '0 || 32'(w_len_full) > MAX_LEN) begin
                        w_state_n = LS_ERR;
                    end else begin
                        w_count_n = '0;
`ifdef UART_LOADER_CHECKSUM_EN
                        w_sum_n   = '0;
`endif
                        w_state_n = LS_DATA;
                    end
                end
                LS_DATA: begin
                    w_we_n    = 1'b1;
                    w_addr_n  = LOAD_BASE + r_count;
                    w_wdata_n = w_byte_data;
                    w_count_n = r_count + MEM_ADDR_W'(1);
`ifdef UART_LOADER_CHECKSUM_EN
                    w_sum_n   = r_sum + w_byte_data;
                    if (LEN_W'(r_count) + LEN_W'(1) == r_len) w_state_n = LS_CSUM;
`else
                    if (LEN_W'(r_count) + LEN_W'(1) == r_len) w_state_n = LS_DONE;
`endif
                end
`ifdef UART_LOADER_CHECKSUM_EN
                LS_CSUM: begin
                    w_state_n = (w_byte_data == r_sum) ? LS_DONE : LS_ERR;
                end
`endif
                default: ;
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state     <= LS_LEN_HI;
            r_len       <= '0;
            r_count     <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rom_ready <= 1'b0;
            r_load_err  <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            r_sum       <= '0;
`endif
        end else begin
            r_state     <= w_state_n;
            r_len       <= w_len_n;
            r_count     <= w_count_n;
            r_mem_we    <= w_we_n;
            r_mem_addr  <= w_addr_n;
            r_mem_wdata <= w_wdata_n;
            r_rom_ready <= (w_state_n == LS_DONE);
            r_load_err  <= (w_state_n == LS_ERR);
`ifdef UART_LOADER_CHECKSUM_EN
            r_sum       <= w_sum_n;
`endif
        end
    end

    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
    assign rom_ready     = r_rom_ready;
    assign load_err      = r_load_err;

endmodule

// File: tb/tb_uart_rom_loader.sv
// tb_uart_rom_loader: directed table of UART frames plus hand sequences for
// start-bit glitch and reset mid-load; a negedge monitor logs memory writes.
module tb_uart_rom_loader;

    localparam int unsigned CPB = 16;
`ifdef UART_LOADER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;
    logic rdy, err;

    uart_rom_loader_if mem_if ();

    uart_rom_loader #(.CLKS_PER_BIT(CPB)) dut (
        .clk_in    (clk),
        .rst_in    (rst_n),
        .rx_in     (rx),
        .mem       (mem_if.master),
        .rom_ready (rdy),
        .load_err  (err)
    );

    always #5 clk = ~clk;

    // Write log captured away from the active edge
    logic [11:0] wr_addr [0:255];
    logic [7:0]  wr_data [0:255];
    int          wr_total  = 0;
    int          dbl_total = 0;
    logic        prev_we   = 1'b0;

    always @(negedge clk) begin
        if (mem_if.mem_we) begin
            wr_addr[8'(wr_total)] <= mem_if.mem_addr;
            wr_data[8'(wr_total)] <= mem_if.mem_wdata;
            wr_total <= wr_total + 1;
        end
        if (mem_if.mem_we && prev_we) dbl_total <= dbl_total + 1;
        prev_we <= mem_if.mem_we;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int vi, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (case %0d): got %0h, expected %0h", nm, vi, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        wait_clk(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clk(CPB);
        end
        rx = stop_bit;
        wait_clk(CPB);
        rx = 1'b1;
        wait_clk(4);
    endtask

    task automatic do_reset(input int vi);
        rx = 1'b1;
        rst_n = 1'b0;
        wait_clk(3);
        chk("rst_we",    vi, 32'(mem_if.mem_we),    32'd0);
        chk("rst_addr",  vi, 32'(mem_if.mem_addr),  32'd0);
        chk("rst_wdata", vi, 32'(mem_if.mem_wdata), 32'd0);
        chk("rst_ready", vi, 32'(rdy), 32'd0);
        chk("rst_err",   vi, 32'(err), 32'd0);
        rst_n = 1'b1;
        wait_clk(2);
    endtask

    // Checks that writes since base match a frame's data bytes (bytes[2..])
    task automatic chk_writes(input int vi, input int base, input int nw, input logic [63:0] bytes);
        chk("wr_count", vi, 32'(wr_total - base), 32'(nw));
        for (int i = 0; i < nw; i++) begin
            chk("wr_addr", vi, 32'(wr_addr[8'(base + i)]), 32'(12'h200 + i));
            chk("wr_data", vi, 32'(wr_data[8'(base + i)]), 32'(bytes[63 - 8 * (i + 2) -: 8]));
        end
    endtask

    typedef struct {
        int          nb;
        logic [63:0] bytes;
        int          bad;
        int          nw;
        logic        rdy;
        logic        err;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        int dbl0;
        logic [63:0] frame;

        // nb, bytes (first byte in MSBs), stop-low index, writes, ready, err
        vecs[0] = '{6, 64'h0003A21E60200000, -1, 3, 1'b1, 1'b0};
        vecs[1] = '{6, 64'h0003A21E60210000, -1, 3, !CS, CS};
        vecs[2] = '{2, 64'h0000000000000000, -1, 0, 1'b0, 1'b1};
        vecs[3] = '{2, 64'h0E01000000000000, -1, 0, 1'b0, 1'b1};
        vecs[4] = '{3, 64'h0E00AB0000000000, -1, 1, 1'b0, 1'b0};
        vecs[5] = '{5, 64'h0003A21E60000000,  3, 1, 1'b0, 1'b1};
        vecs[6] = '{4, 64'h0001555500000000, -1, 1, 1'b1, 1'b0};
        vecs[7] = '{5, 64'h0003A21E60000000, -1, 3, !CS, 1'b0};

        wait_clk(2);
        for (int v = 0; v < NV; v++) begin
            do_reset(v);
            base = wr_total;
            dbl0 = dbl_total;
            for (int i = 0; i < vecs[v].nb; i++)
                send_byte(vecs[v].bytes[63 - 8 * i -: 8], (i != vecs[v].bad));
            wait_clk(20);
            chk_writes(v, base, vecs[v].nw, vecs[v].bytes);
            chk("rom_ready", v, 32'(rdy), 32'(vecs[v].rdy));
            chk("load_err",  v, 32'(err), 32'(vecs[v].err));
            chk("we_width",  v, 32'(dbl_total - dbl0), 32'd0);
        end

        // Start-bit glitch on idle line, then a normal frame
        frame = 64'h0003A21E60200000;
        do_reset(100);
        base = wr_total;
        rx = 1'b0;
        wait_clk(3);
        rx = 1'b1;
        wait_clk(40);
        chk("glitch_wr",  100, 32'(wr_total - base), 32'd0);
        chk("glitch_err", 100, 32'(err), 32'd0);
        for (int i = 0; i < 6; i++) send_byte(frame[63 - 8 * i -: 8], 1'b1);
        wait_clk(20);
        chk_writes(100, base, 3, frame);
        chk("glitch_ready", 100, 32'(rdy), 32'd1);
        chk("glitch_err2",  100, 32'(err), 32'd0);

        // Reset after two data bytes, then full reload and trailing bytes
        do_reset(101);
        for (int i = 0; i < 4; i++) send_byte(frame[63 - 8 * i -: 8], 1'b1);
        rst_n = 1'b0;
        wait_clk(2);
        chk("midrst_we",    101, 32'(mem_if.mem_we), 32'd0);
        chk("midrst_ready", 101, 32'(rdy), 32'd0);
        rst_n = 1'b1;
        wait_clk(2);
        base = wr_total;
        dbl0 = dbl_total;
        for (int i = 0; i < 6; i++) send_byte(frame[63 - 8 * i -: 8], 1'b1);
        wait_clk(20);
        chk_writes(101, base, 3, frame);
        chk("reload_ready", 101, 32'(rdy), 32'd1);
        for (int k = 0; k < 10; k++) begin
            send_byte(8'(8'h11 * k + 8'h07), 1'b1);
            chk("trail_ready", 101, 32'(rdy), 32'd1);
        end
        chk("trail_wr",  101, 32'(wr_total - base), 32'd3);
        chk("trail_err", 101, 32'(err), 32'd0);
        chk("trail_we_width", 101, 32'(dbl_total - dbl0), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rom_loader.md
# uart_rom_loader

Receives a CHIP-8 program over a UART serial line and writes it byte-by-byte into system memory starting at 0x200, then raises `rom_ready`. It replaces the file-based loader upstream of the CPU: the top level ANDs `rom_ready` with `font_ready` to form `system_ready`. It shares the memory write path only during load; the font region 0x000–0x04F is never written.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per UART bit (100 MHz / 115200); must be ≥ 4.
- `LOAD_BASE`, 12'h200, address of the first program byte.
- `MAX_LEN`, 3584, largest accepted program length in bytes (0x200–0xFFF).
- `clk_in`  in  1  system clock; all logic on posedge.
- `rst_in`  in  1  synchronous, active-low reset.
- `rx_in`  in  1  UART receive line, asynchronous, idle high, 8N1, LSB first.
- `mem_we`  out  1  one-cycle memory write strobe.
- `mem_addr`  out  12  write address.
- `mem_wdata`  out  8  write data.
- `rom_ready`  out  1  program fully loaded; sticky until reset.
- `load_err`  out  1  load aborted; sticky until reset.

## Operation
- Frame format: LEN_HI, LEN_LO (big-endian 16-bit length N), then N data bytes, then (if checksum compiled in) one checksum byte.
- FSM states: LEN_HI → LEN_LO → DATA → [CSUM] → DONE; any state → ERR on error.
- LEN_HI: capture byte into len[15:8]. LEN_LO: capture len[7:0]; if N == 0 or N > MAX_LEN → ERR, else clear byte counter and running sum, → DATA.
- DATA: each received byte written to `LOAD_BASE + count` (12-bit), count++, sum += byte (8-bit wrap). After byte N → CSUM (or DONE when compiled out).
- DONE: `rom_ready`=1; further received bytes ignored, no writes.
- ERR: `load_err`=1; all bytes ignored, no writes. Only reset exits ERR or DONE.
- UART framing error (stop bit sampled low): byte discarded, FSM → ERR.
- Start-bit glitch (rx high at mid-start sample): receiver returns to idle, no byte, no error.

## Timing
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `rom_ready`=0, `load_err`=0, FSM=LEN_HI, receiver idle.
- `rx_in` passes a 2-flop synchronizer before use (2-cycle input latency).
- Receiver: start edge detected on synchronized falling edge; samples at CLKS_PER_BIT/2 into start bit, then every CLKS_PER_BIT for 8 data bits and stop bit. Byte-valid pulse one cycle after stop sample.
- `mem_we`, `mem_addr`, `mem_wdata` registered: valid the cycle after byte-valid, `mem_we` high exactly one cycle. Address/data hold until next write.
- `rom_ready` rises the cycle after the last byte-valid (checksum byte, or last data byte when compiled out); same for `load_err` on the failing byte.
- Reset mid-load: all state cleared the next edge; a partially received byte is dropped; memory already written is not erased.

## Configuration
- `UART_LOADER_CHECKSUM_EN` defined: CSUM state present; byte after data compared to 8-bit sum of data bytes; match → DONE, mismatch → ERR.
- Undefined: no CSUM state, no sum register; DONE directly after byte N; `load_err` only from length or framing errors.

## Structure
- Shared package `chip8_pkg`: `MEM_ADDR_W`=12, `ROM_BASE`=12'h200, `ROM_MAX_LEN`=3584, loader state enum `loader_state_t`.
- One sub-module: `uart_rx` (synchronizer, bit timer, shift register, `byte_valid`/`byte_data`/`frame_err` outputs), parameterized by `CLKS_PER_BIT`.

## Test plan
(CLKS_PER_BIT=16 for all.)
- Send 00 03 A2 1E 60 + checksum 0x20 (CHECKSUM_EN) → writes 0x200=A2, 0x201=1E, 0x202=60, each a single-cycle `mem_we`; `rom_ready`=1, `load_err`=0.
- Same frame with checksum 0x21 → three writes occur, then `load_err`=1, `rom_ready` stays 0.
- Send 00 00 → `load_err`=1 after LEN_LO, no writes; send 0E 01 (3585) → same.
- Byte with stop bit forced low during DATA → byte not written, `load_err`=1; later bytes ignored.
- 3-cycle low glitch on idle `rx_in`, then valid frame → no spurious byte; load completes normally.
- Assert `rst_in`=0 after 2 of 3 data bytes, release, resend full frame → `rom_ready`=1, 0x200–0x202 correct, `rom_ready` held through 10 extra trailing bytes with no writes.
